// File: rtl/bsg_bedrock_mem_responder_if.sv
// Command/response bundle between a BedRock memory requester and the responder.
// The slave side is the responder; the master side issues commands and
// consumes responses.
interface bsg_bedrock_mem_responder_if #(
  parameter int paddr_width_p   = 40,
  parameter int payload_width_p = 16
);
  logic [3:0]                 mem_cmd_msg_type_i;
  logic [paddr_width_p-1:0]   mem_cmd_addr_i;
  logic [2:0]                 mem_cmd_size_i;
  logic [payload_width_p-1:0] mem_cmd_payload_i;
  logic [63:0]                mem_cmd_data_i;
  logic                       mem_cmd_v_i;
  logic                       mem_cmd_ready_o;

  logic [3:0]                 mem_resp_msg_type_o;
  logic [paddr_width_p-1:0]   mem_resp_addr_o;
  logic [2:0]                 mem_resp_size_o;
  logic [payload_width_p-1:0] mem_resp_payload_o;
  logic [63:0]                mem_resp_data_o;
  logic                       mem_resp_v_o;
  logic                       mem_resp_yumi_i;

  modport slave (
    input  mem_cmd_msg_type_i, mem_cmd_addr_i, mem_cmd_size_i,
           mem_cmd_payload_i, mem_cmd_data_i, mem_cmd_v_i, mem_resp_yumi_i,
    output mem_cmd_ready_o, mem_resp_msg_type_o, mem_resp_addr_o,
           mem_resp_size_o, mem_resp_payload_o, mem_resp_data_o, mem_resp_v_o
  );

  modport master (
    output mem_cmd_msg_type_i, mem_cmd_addr_i, mem_cmd_size_i,
           mem_cmd_payload_i, mem_cmd_data_i, mem_cmd_v_i, mem_resp_yumi_i,
    input  mem_cmd_ready_o, mem_resp_msg_type_o, mem_resp_addr_o,
           mem_resp_size_o, mem_resp_payload_o, mem_resp_data_o, mem_resp_v_o
  );
endinterface

// File: rtl/bsg_bedrock_mem_responder.sv
// Single-outstanding BedRock memory responder backed by a 64-bit-wide 1RW
// SRAM with byte-write mask. Reads take two cycles to respond, writes and
// unsupported message types take one.
module bsg_bedrock_mem_responder #(
  parameter int els_p           = 512,
  parameter int paddr_width_p   = 40,
  parameter int payload_width_p = 16
) (
  input logic clk_i,
  input logic reset_i,
  bsg_bedrock_mem_responder_if.slave bus
);
  localparam int lg_els_lp = $clog2(els_p);

  typedef enum logic [1:0] {READY, READ_WAIT, RESP} state_e;
  state_e state_r, state_n;

  // Size codes above 3 collapse to a full 8-byte access.
  function automatic logic [1:0] eff_size(input logic [2:0] size);
    return (size > 3'd3) ? 2'd3 : size[1:0];
  endfunction

  // Byte offset within the word, aligned down to the access size.
  function automatic logic [2:0] byte_off(input logic [2:0] addr_lo, input logic [2:0] size);
    logic [2:0] off;
    case (eff_size(size))
      2'd0:    off = addr_lo;
      2'd1:    off = {addr_lo[2:1], 1'b0};
      2'd2:    off = {addr_lo[2], 2'b00};
      default: off = 3'd0;
    endcase
    return off;
  endfunction

  function automatic logic [7:0] byte_mask(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (eff_size(size))
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [63:0] data_mask(input logic [2:0] size);
    logic [63:0] m;
    case (eff_size(size))
      2'd0:    m = 64'h0000_0000_0000_00FF;
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  logic [63:0]          mem_r [els_p];
  logic [63:0]          rdata_p1;
  logic                 cmd_ready;
  logic                 cmd_fire_p0;
  logic                 sram_v_p0;
  logic                 sram_w_p0;
  logic                 is_rd_p0;
  logic                 is_wr_p0;
  logic [2:0]           off_p0;
  logic [lg_els_lp-1:0] idx_p0;
  logic [7:0]           wmask_p0;
  logic [63:0]          wdata_p0;

  logic [3:0]                 resp_msg_type_r;
  logic [paddr_width_p-1:0]   resp_addr_r;
  logic [2:0]                 resp_size_r;
  logic [payload_width_p-1:0] resp_payload_r;
  logic [63:0]                resp_data_r;
  logic                       resp_v_r;

  // ---- stage p0: command decode at acceptance ----
  assign is_rd_p0    = (bus.mem_cmd_msg_type_i == 4'd0) || (bus.mem_cmd_msg_type_i == 4'd2);
  assign is_wr_p0    = (bus.mem_cmd_msg_type_i == 4'd1) || (bus.mem_cmd_msg_type_i == 4'd3);
  assign off_p0      = byte_off(bus.mem_cmd_addr_i[2:0], bus.mem_cmd_size_i);
  assign idx_p0      = bus.mem_cmd_addr_i[3 +: lg_els_lp];
  assign wmask_p0    = byte_mask(bus.mem_cmd_size_i, off_p0);
  assign wdata_p0    = bus.mem_cmd_data_i << {off_p0, 3'b000};
  assign cmd_fire_p0 = cmd_ready & bus.mem_cmd_v_i;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= READY;
    else         state_r <= state_n;
  end

  // Next-state, command acceptance and SRAM enables
  always_comb begin
    state_n   = state_r;
    cmd_ready = 1'b0;
    sram_v_p0 = 1'b0;
    sram_w_p0 = 1'b0;
    case (state_r)
      READY: begin
        cmd_ready = ~reset_i;
        if (cmd_ready && bus.mem_cmd_v_i) begin
          if (is_rd_p0) begin
            sram_v_p0 = 1'b1;
            state_n   = READ_WAIT;
          end else if (is_wr_p0) begin
            sram_v_p0 = 1'b1;
            sram_w_p0 = 1'b1;
            state_n   = RESP;
          end else begin
            state_n   = RESP;
          end
        end
      end
      READ_WAIT: state_n = RESP;
      RESP:      if (bus.mem_resp_yumi_i) state_n = READY;
      default:   state_n = READY;
    endcase
  end

  // ---- stage p1: SRAM access (byte-masked write or registered read) ----
  always_ff @(posedge clk_i) begin
    if (sram_v_p0) begin
      if (sram_w_p0) begin
        for (int b = 0; b < 8; b++)
          if (wmask_p0[b]) mem_r[idx_p0][8*b +: 8] <= wdata_p0[8*b +: 8];
      end else begin
        rdata_p1 <= mem_r[idx_p0];
      end
    end
  end

  // Response registers: header captured at acceptance, read data aligned in READ_WAIT
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resp_msg_type_r <= '0;
      resp_addr_r     <= '0;
      resp_size_r     <= '0;
      resp_payload_r  <= '0;
      resp_data_r     <= '0;
      resp_v_r        <= 1'b0;
    end else begin
      resp_v_r <= (state_n == RESP);
      if (cmd_fire_p0) begin
        resp_msg_type_r <= bus.mem_cmd_msg_type_i;
        resp_addr_r     <= bus.mem_cmd_addr_i;
        resp_size_r     <= bus.mem_cmd_size_i;
        resp_payload_r  <= bus.mem_cmd_payload_i;
        resp_data_r     <= '0;
      end
      if (state_r == READ_WAIT)
        resp_data_r <= (rdata_p1 >> {byte_off(resp_addr_r[2:0], resp_size_r), 3'b000})
                       & data_mask(resp_size_r);
    end
  end

  assign bus.mem_cmd_ready_o     = cmd_ready;
  assign bus.mem_resp_msg_type_o = resp_msg_type_r;
  assign bus.mem_resp_addr_o     = resp_addr_r;
  assign bus.mem_resp_size_o     = resp_size_r;
  assign bus.mem_resp_payload_o  = resp_payload_r;
  assign bus.mem_resp_data_o     = resp_data_r;
  assign bus.mem_resp_v_o        = resp_v_r;
endmodule

// File: tb/tb_bsg_bedrock_mem_responder.sv
// Randomized and directed bench for bsg_bedrock_mem_responder against a
// byte-array memory model.
module tb_bsg_bedrock_mem_responder;
  localparam int els_lp     = 512;
  localparam int paddr_lp   = 40;
  localparam int payload_lp = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bsg_bedrock_mem_responder_if #(.paddr_width_p(paddr_lp), .payload_width_p(payload_lp)) bus ();

  bsg_bedrock_mem_responder #(
    .els_p(els_lp), .paddr_width_p(paddr_lp), .payload_width_p(payload_lp)
  ) dut (
    .clk_i(clk), .reset_i(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] ref_mem [els_lp*8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] size);
    return (size >= 3'd3) ? 8 : (1 << size);
  endfunction

  // First byte touched in the flat byte array: word index wraps modulo els.
  function automatic int first_byte(input logic [paddr_lp-1:0] addr, input logic [2:0] size);
    int c, idx, off;
    c   = nbytes(size);
    idx = int'((addr >> 3) % els_lp);
    off = (size >= 3'd3) ? 0 : (int'(addr[2:0]) / c) * c;
    return idx * 8 + off;
  endfunction

  task automatic model_write(input logic [paddr_lp-1:0] a, input logic [2:0] s, input logic [63:0] d);
    int b;
    b = first_byte(a, s);
    for (int i = 0; i < nbytes(s); i++) ref_mem[b + i] = d[8*i +: 8];
  endtask

  function automatic logic [63:0] model_read(input logic [paddr_lp-1:0] a, input logic [2:0] s);
    logic [63:0] r;
    int b;
    r = '0;
    b = first_byte(a, s);
    for (int i = 0; i < nbytes(s); i++) r[8*i +: 8] = ref_mem[b + i];
    return r;
  endfunction

  task automatic drive_idle();
    bus.mem_cmd_v_i        = 1'b0;
    bus.mem_cmd_msg_type_i = '0;
    bus.mem_cmd_addr_i     = '0;
    bus.mem_cmd_size_i     = '0;
    bus.mem_cmd_payload_i  = '0;
    bus.mem_cmd_data_i     = '0;
    bus.mem_resp_yumi_i    = 1'b0;
  endtask

  // Issue one command, check latency and every response field, optionally
  // stall the response for 'hold' cycles, retire it and check ready returns.
  task automatic do_cmd(input logic [3:0] t, input logic [paddr_lp-1:0] a, input logic [2:0] s,
                        input logic [63:0] d, input logic [payload_lp-1:0] p, input int hold,
                        input string tag, output logic [63:0] got_d);
    logic [63:0] exp_d;
    int exp_lat, lat;
    bit ok;
    if (t == 4'd0 || t == 4'd2) begin
      exp_d = model_read(a, s); exp_lat = 2;
    end else begin
      if (t == 4'd1 || t == 4'd3) model_write(a, s, d);
      exp_d = '0; exp_lat = 1;
    end
    @(negedge clk);
    bus.mem_cmd_msg_type_i = t;
    bus.mem_cmd_addr_i     = a;
    bus.mem_cmd_size_i     = s;
    bus.mem_cmd_data_i     = d;
    bus.mem_cmd_payload_i  = p;
    bus.mem_cmd_v_i        = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_cmd_ready_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, " accept"}, 64'(ok), 64'd1);
    @(posedge clk);
    #1 bus.mem_cmd_v_i = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (bus.mem_resp_v_o) break;
    end
    got_d = bus.mem_resp_data_o;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " type"}, 64'(bus.mem_resp_msg_type_o), 64'(t));
    check({tag, " addr"}, 64'(bus.mem_resp_addr_o), 64'(a));
    check({tag, " size"}, 64'(bus.mem_resp_size_o), 64'(s));
    check({tag, " payload"}, 64'(bus.mem_resp_payload_o), 64'(p));
    check({tag, " data"}, bus.mem_resp_data_o, exp_d);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold v"}, 64'(bus.mem_resp_v_o), 64'd1);
      check({tag, " hold ready"}, 64'(bus.mem_cmd_ready_o), 64'd0);
      check({tag, " hold data"}, bus.mem_resp_data_o, exp_d);
      check({tag, " hold addr"}, 64'(bus.mem_resp_addr_o), 64'(a));
    end
    bus.mem_resp_yumi_i = 1'b1;
    check({tag, " ready at yumi"}, 64'(bus.mem_cmd_ready_o), 64'd0);
    @(posedge clk);
    #1 bus.mem_resp_yumi_i = 1'b0;
    @(negedge clk);
    check({tag, " ready after yumi"}, 64'(bus.mem_cmd_ready_o), 64'd1);
    check({tag, " v after yumi"}, 64'(bus.mem_resp_v_o), 64'd0);
  endtask

  initial begin
    logic [63:0] got, x4, x5;
    logic [paddr_lp-1:0] ra;
    int vseen;

    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", 64'(bus.mem_cmd_ready_o), 64'd0);
    check("reset v", 64'(bus.mem_resp_v_o), 64'd0);
    check("reset data", bus.mem_resp_data_o, 64'd0);
    check("reset addr", 64'(bus.mem_resp_addr_o), 64'd0);
    check("reset payload", 64'(bus.mem_resp_payload_o), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready after reset", 64'(bus.mem_cmd_ready_o), 64'd1);

    // Give every word a known value so the model never reads undefined bytes.
    for (int w = 0; w < els_lp; w++)
      do_cmd(4'd1, paddr_lp'(w * 8), 3'd3, {$urandom, $urandom}, 16'(w), 0, "init", got);

    // Write then read back a full word.
    do_cmd(4'd1, 40'h10, 3'd3, 64'h1122334455667788, 16'h00AB, 0, "s1 wr", got);
    check("s1 wr data zero", got, 64'd0);
    do_cmd(4'd0, 40'h10, 3'd3, 64'd0, 16'h0001, 0, "s1 rd", got);
    check("s1 rd value", got, 64'h1122334455667788);

    // Sub-word write and sub-word reads.
    do_cmd(4'd3, 40'h13, 3'd0, 64'hFF, 16'h0002, 0, "s2 wr", got);
    do_cmd(4'd0, 40'h10, 3'd3, 64'd0, 16'h0003, 0, "s2 rd", got);
    check("s2 rd value", got, 64'h11223344FF667788);
    do_cmd(4'd2, 40'h12, 3'd1, 64'd0, 16'h0004, 0, "s2 ucrd", got);
    check("s2 ucrd value", got, 64'h000000000000FF66);

    // Backpressure on a read response.
    do_cmd(4'd0, 40'h10, 3'd3, 64'd0, 16'h0005, 5, "s3 bp", got);

    // Address wrap and unsupported type.
    x4 = 64'hCAFEF00D12345678;
    do_cmd(4'd1, 40'h1010, 3'd3, x4, 16'h0006, 0, "s4 wr wrap", got);
    do_cmd(4'd0, 40'h10, 3'd3, 64'd0, 16'h0007, 0, "s4 rd wrap", got);
    check("s4 wrap value", got, x4);
    do_cmd(4'd7, 40'h10, 3'd3, 64'hDEADBEEFDEADBEEF, 16'h0008, 0, "s4 bad", got);
    check("s4 bad data zero", got, 64'd0);
    do_cmd(4'd0, 40'h10, 3'd3, 64'd0, 16'h0009, 0, "s4 rd after bad", got);
    check("s4 sram unchanged", got, x4);

    // Reset while a read is waiting on the SRAM.
    x5 = 64'h0F1E2D3C4B5A6978;
    do_cmd(4'd1, 40'h40, 3'd3, x5, 16'h000A, 0, "s5 wr", got);
    @(negedge clk);
    bus.mem_cmd_msg_type_i = 4'd0;
    bus.mem_cmd_addr_i     = 40'h40;
    bus.mem_cmd_size_i     = 3'd3;
    bus.mem_cmd_v_i        = 1'b1;
    check("s5 ready before rd", 64'(bus.mem_cmd_ready_o), 64'd1);
    @(posedge clk);
    #1 bus.mem_cmd_v_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("s5 ready in reset", 64'(bus.mem_cmd_ready_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("s5 ready in reset 2", 64'(bus.mem_cmd_ready_o), 64'd0);
    check("s5 v in reset", 64'(bus.mem_resp_v_o), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("s5 ready after reset", 64'(bus.mem_cmd_ready_o), 64'd1);
    vseen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_resp_v_o) vseen++;
      @(negedge clk);
    end
    check("s5 no stale resp", 64'(vseen), 64'd0);
    do_cmd(4'd0, 40'h40, 3'd3, 64'd0, 16'h000B, 0, "s5 rd", got);
    check("s5 rd value", got, x5);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] t;
      t  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      ra = paddr_lp'({$urandom, $urandom});
      do_cmd(t, ra, 3'($urandom_range(0, 7)), {$urandom, $urandom},
             payload_lp'($urandom), $urandom_range(0, 3), "rand", got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
